faultify_cut_harness: RTL and testbench

Parametrised, sequential test harness around a fault-injectable circuit under test (CUT) in the Faultify flow. It accepts one test vector at a time, drives the CUT's test, start and injection inputs, and waits for the CUT's ready. It then compares the captured result against a golden vector under a mask and reports pass, fail or timeout. It sits between the AXI-side vector sequencer and the CUT, replacing fixed-width CUT wiring with configurable widths and a cycle-accurate injection window.

---
 rtl/faultify_harness_pkg.sv | 9 +
 rtl/faultify_inj_window.sv | 22 ++
 rtl/faultify_cut_harness.sv | 154 +++++++++++++++
 tb/tb_faultify_cut_harness.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/faultify_harness_pkg.sv
// faultify_harness_pkg: shared FSM state type and default widths for the Faultify CUT harness.
package faultify_harness_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, WAIT, DONE} harnessStateT;

    localparam int CYC_W_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/faultify_inj_window.sv
// faultify_inj_window: combinational injection-window comparator.
// Ports: cycCnt (current cycle), delay (first injected cycle), len (injected
// cycle count), active (FSM in APPLY/WAIT) -> injEn (inject this cycle).
module faultify_inj_window
    import faultify_harness_pkg::*;
#(
    parameter int CYC_W = CYC_W_DEFAULT
) (
    input  logic [CYC_W-1:0] cycCnt,
    input  logic [CYC_W-1:0] delay,
    input  logic [CYC_W-1:0] len,
    input  logic             active,
    output logic             injEn
);

    // One extra bit so delay+len never wraps; len=0 gives an empty window.
    logic [CYC_W:0] winEnd;

    assign winEnd = {1'b0, delay} + {1'b0, len};
    assign injEn  = active && (cycCnt >= delay) && ({1'b0, cycCnt} < winEnd);

endmodule

// File: rtl/faultify_cut_harness.sv
// faultify_cut_harness: sequential test harness driving a fault-injectable CUT.
// Ports: vec_* accept one test vector (test, golden, mask, injection pattern,
// delay, len); cut_* drive the CUT and collect its result; res_* present the
// outcome (result, masked diff, fail, timeout) until consumed; clr_cnt_i,
// run_cnt_o, fail_cnt_o are the saturating run/fail statistics.
// rst is asynchronous, active-low.
// Macro FAULTIFY_HARNESS_TIMEOUT_EN: when defined, WAIT aborts after TIMEOUT
// cycles; otherwise WAIT waits forever and res_timeout_o is constant 0.
module faultify_cut_harness
    import faultify_harness_pkg::*;
#(
    parameter int TV_W    = 70,
    parameter int RV_W    = 41,
    parameter int INJ_W   = 268,
    parameter int CYC_W   = CYC_W_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [TV_W-1:0]  vec_test_i,
    input  logic [RV_W-1:0]  vec_golden_i,
    input  logic [RV_W-1:0]  vec_mask_i,
    input  logic [INJ_W-1:0] inj_vector_i,
    input  logic [CYC_W-1:0] inj_delay_i,
    input  logic [CYC_W-1:0] inj_len_i,
    output logic [TV_W-1:0]  cut_test_o,
    output logic             cut_start_o,
    output logic [INJ_W-1:0] cut_inj_o,
    input  logic [RV_W-1:0]  cut_result_i,
    input  logic             cut_ready_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [RV_W-1:0]  res_result_o,
    output logic [RV_W-1:0]  res_diff_o,
    output logic             res_fail_o,
    output logic             res_timeout_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    harnessStateT     state, nextState;
    logic [TV_W-1:0]  testReg;
    logic [RV_W-1:0]  goldenReg, maskReg, resultReg, diffReg;
    logic [INJ_W-1:0] injReg;
    logic [CYC_W-1:0] delayReg, lenReg, cycCnt;
    logic [CNT_W-1:0] runCnt, failCnt;
    logic             failReg, timeoutReg, timeoutHit, injEn, accept;
    logic [RV_W-1:0]  cmpDiff;

    assign accept  = (state == IDLE) && vec_valid_i;
    assign cmpDiff = (cut_result_i ^ goldenReg) & maskReg;

`ifdef FAULTIFY_HARNESS_TIMEOUT_EN
    assign timeoutHit = (cycCnt == CYC_W'(TIMEOUT));
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = vec_valid_i ? APPLY : IDLE;
            APPLY:   nextState = WAIT;
            WAIT:    nextState = (cut_ready_i || timeoutHit) ? DONE : WAIT;
            DONE:    nextState = res_ready_i ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            testReg    <= '0;
            goldenReg  <= '0;
            maskReg    <= '0;
            injReg     <= '0;
            delayReg   <= '0;
            lenReg     <= '0;
            cycCnt     <= '0;
            resultReg  <= '0;
            diffReg    <= '0;
            failReg    <= 1'b0;
            timeoutReg <= 1'b0;
        end else begin
            if (accept) begin
                testReg   <= vec_test_i;
                goldenReg <= vec_golden_i;
                maskReg   <= vec_mask_i;
                injReg    <= inj_vector_i;
                delayReg  <= inj_delay_i;
                lenReg    <= inj_len_i;
                cycCnt    <= '0;
            end else if (state == APPLY || state == WAIT) begin
                // Saturate so a very long WAIT cannot wrap back into the window.
                cycCnt <= (cycCnt == '1) ? cycCnt : cycCnt + 1'b1;
            end
            // Ready is checked first so it wins over a simultaneous timeout.
            if (state == WAIT && cut_ready_i) begin
                resultReg  <= cut_result_i;
                diffReg    <= cmpDiff;
                failReg    <= |cmpDiff;
                timeoutReg <= 1'b0;
            end else if (state == WAIT && timeoutHit) begin
                resultReg  <= '0;
                diffReg    <= maskReg;
                failReg    <= 1'b1;
                timeoutReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            runCnt  <= '0;
            failCnt <= '0;
        end else if (clr_cnt_i) begin
            runCnt  <= '0;
            failCnt <= '0;
        end else if (state == DONE && res_ready_i) begin
            runCnt <= (runCnt == '1) ? runCnt : runCnt + 1'b1;
            if (failReg) failCnt <= (failCnt == '1) ? failCnt : failCnt + 1'b1;
        end
    end

    faultify_inj_window #(.CYC_W(CYC_W)) uWindow (
        .cycCnt (cycCnt),
        .delay  (delayReg),
        .len    (lenReg),
        .active (state == APPLY || state == WAIT),
        .injEn  (injEn)
    );

    // vec_ready_o is gated by rst so it reads 0 while reset is held.
    assign vec_ready_o   = (state == IDLE) && rst;
    assign cut_test_o    = testReg;
    assign cut_start_o   = (state == APPLY);
    assign cut_inj_o     = injReg & {INJ_W{injEn}};
    assign res_valid_o   = (state == DONE);
    assign res_result_o  = resultReg;
    assign res_diff_o    = diffReg;
    assign res_fail_o    = failReg;
    assign res_timeout_o = timeoutReg;
    assign run_cnt_o     = runCnt;
    assign fail_cnt_o    = failCnt;

endmodule

// File: tb/tb_faultify_cut_harness.sv
// tb_faultify_cut_harness: directed scoreboard bench for faultify_cut_harness.
module tb_faultify_cut_harness;

    localparam int TV_W    = 70;
    localparam int RV_W    = 41;
    localparam int INJ_W   = 268;
    localparam int CYC_W   = 16;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [RV_W-1:0] result;
        logic [RV_W-1:0] diff;
        logic            fail;
        logic            timeout;
    } expT;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             vecValid = 1'b0;
    logic             vecReady;
    logic [TV_W-1:0]  vecTest = '0;
    logic [RV_W-1:0]  vecGolden = '0;
    logic [RV_W-1:0]  vecMask = '0;
    logic [INJ_W-1:0] injVector = '0;
    logic [CYC_W-1:0] injDelay = '0;
    logic [CYC_W-1:0] injLen = '0;
    logic [TV_W-1:0]  cutTest;
    logic             cutStart;
    logic [INJ_W-1:0] cutInj;
    logic [RV_W-1:0]  cutResult = '0;
    logic             cutReady = 1'b0;
    logic             resValid;
    logic             resReady = 1'b0;
    logic [RV_W-1:0]  resResult;
    logic [RV_W-1:0]  resDiff;
    logic             resFail;
    logic             resTimeout;
    logic             clrCnt = 1'b0;
    logic [CNT_W-1:0] runCnt;
    logic [CNT_W-1:0] failCnt;

    int  checks = 0;
    int  errors = 0;
    int  expRun = 0;
    int  expFail = 0;
    expT sb[$];
    expT lastExp;

    faultify_cut_harness #(
        .TV_W(TV_W), .RV_W(RV_W), .INJ_W(INJ_W),
        .CYC_W(CYC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vec_valid_i   (vecValid),
        .vec_ready_o   (vecReady),
        .vec_test_i    (vecTest),
        .vec_golden_i  (vecGolden),
        .vec_mask_i    (vecMask),
        .inj_vector_i  (injVector),
        .inj_delay_i   (injDelay),
        .inj_len_i     (injLen),
        .cut_test_o    (cutTest),
        .cut_start_o   (cutStart),
        .cut_inj_o     (cutInj),
        .cut_result_i  (cutResult),
        .cut_ready_i   (cutReady),
        .res_valid_o   (resValid),
        .res_ready_i   (resReady),
        .res_result_o  (resResult),
        .res_diff_o    (resDiff),
        .res_fail_o    (resFail),
        .res_timeout_o (resTimeout),
        .clr_cnt_i     (clrCnt),
        .run_cnt_o     (runCnt),
        .fail_cnt_o    (failCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected outcome whenever a result handshake is presented.
    always @(negedge clk) begin
        if (rst && resValid && resReady) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected result %0h", resResult);
            end else begin
                expT e;
                e = sb.pop_front();
                check("res_result", resResult, e.result);
                check("res_diff", resDiff, e.diff);
                check("res_fail", resFail, e.fail);
                check("res_timeout", resTimeout, e.timeout);
            end
        end
    end

    // Accepts one vector, then steps through APPLY/WAIT checking the injection
    // window each cycle; drives ready in the cycle whose counter is readyAt.
    task automatic runVec(input logic [TV_W-1:0] t, input logic [RV_W-1:0] g,
                          input logic [RV_W-1:0] m, input logic [RV_W-1:0] r,
                          input logic [INJ_W-1:0] inj, input int dly, input int ln,
                          input int readyAt, input logic expTo);
        int lastC;
        expT e;
        if (expTo) begin
            e.result = '0; e.diff = m; e.fail = 1'b1; e.timeout = 1'b1;
        end else begin
            e.result = r; e.diff = (r ^ g) & m; e.fail = |((r ^ g) & m); e.timeout = 1'b0;
        end
        sb.push_back(e);
        lastExp = e;
        lastC = expTo ? TIMEOUT : readyAt;
        vecTest = t; vecGolden = g; vecMask = m; injVector = inj;
        injDelay = CYC_W'(dly); injLen = CYC_W'(ln); vecValid = 1'b1;
        check("vec_ready_idle", vecReady, 1'b1);
        tick();
        vecValid = 1'b0;
        check("cut_start", cutStart, 1'b1);
        check("cut_test", cutTest, t);
        for (int c = 0; c <= lastC; c++) begin
            check($sformatf("cut_inj_c%0d", c), cutInj,
                  (c >= dly && c < dly + ln) ? inj : '0);
            check("res_valid_early", resValid, 1'b0);
            if (!expTo && c == readyAt) begin
                cutReady = 1'b1;
                cutResult = r;
            end
            tick();
        end
        cutReady = 1'b0;
        check("res_valid_done", resValid, 1'b1);
        check("cut_start_done", cutStart, 1'b0);
    endtask

    // Holds the result for `hold` cycles, then consumes it (optionally with a clear).
    task automatic consume(input int hold, input logic clr);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", resValid, 1'b1);
            check("hold_vec_ready", vecReady, 1'b0);
            check("hold_result", resResult, lastExp.result);
            check("hold_diff", resDiff, lastExp.diff);
            check("hold_fail", resFail, lastExp.fail);
            tick();
        end
        resReady = 1'b1;
        clrCnt = clr;
        tick();
        resReady = 1'b0;
        clrCnt = 1'b0;
        if (clr) begin
            expRun = 0;
            expFail = 0;
        end else begin
            expRun++;
            if (lastExp.fail) expFail++;
        end
        check("vec_ready_after", vecReady, 1'b1);
        check("res_valid_after", resValid, 1'b0);
        check("run_cnt", runCnt, expRun);
        check("fail_cnt", failCnt, expFail);
    endtask

    initial begin
        logic [TV_W-1:0]  t0;
        logic [RV_W-1:0]  g0;
        logic [RV_W-1:0]  bit40;
        logic [INJ_W-1:0] injAll;
        t0 = 70'h3_0123_4567_89AB_CDEF;
        g0 = 41'h1_2345_6789A;
        bit40 = '0;
        bit40[40] = 1'b1;
        injAll = '1;

        // Reset state
        #2;
        check("rst_vec_ready", vecReady, 1'b0);
        check("rst_cut_start", cutStart, 1'b0);
        check("rst_cut_inj", cutInj, '0);
        check("rst_cut_test", cutTest, '0);
        check("rst_res_valid", resValid, 1'b0);
        check("rst_run_cnt", runCnt, 0);
        check("rst_fail_cnt", failCnt, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_vec_ready", vecReady, 1'b1);

        // Clean run: len=0, result=golden, ready sampled at accept edge + 7
        runVec(t0, g0, '1, g0, injAll, 0, 0, 6, 1'b0);
        consume(0, 1'b0);

        // Injection window delay=2 len=3, bit 2 set
        runVec(~t0, ~g0, '1, ~g0, INJ_W'(4), 2, 3, 6, 1'b0);
        consume(0, 1'b0);

        // Masked mismatch at bits 0 and 40, only bit 40 checked
        runVec(t0 ^ 70'h5, g0, bit40, g0 ^ bit40 ^ 41'h1, '0, 0, 0, 3, 1'b0);
        consume(0, 1'b0);

        // Ready exactly at counter 8 (ready wins over timeout)
        runVec(t0, g0, '1, g0, '0, 0, 0, 8, 1'b0);
        consume(0, 1'b0);

`ifdef FAULTIFY_HARNESS_TIMEOUT_EN
        // CUT never ready: abort at counter 8
        runVec(t0, g0, 41'h0FF_0000_FFFF, g0, '0, 0, 0, 0, 1'b1);
        consume(0, 1'b0);
`endif

        // Back-pressure for 4 cycles, then clear coinciding with the handshake
        runVec(t0, g0, '1, g0 ^ 41'h10, injAll, 1, 1, 2, 1'b0);
        consume(4, 1'b1);

        // Make the counters non-zero before the reset test
        runVec(t0, g0, '1, g0 ^ 41'h3, '0, 0, 0, 1, 1'b0);
        consume(0, 1'b0);

        // Reset mid-WAIT: injection drops asynchronously, nothing is reported
        sb.push_back(lastExp);
        vecTest = t0; vecGolden = g0; vecMask = '1; injVector = injAll;
        injDelay = '0; injLen = CYC_W'(10); vecValid = 1'b1;
        tick();
        vecValid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_wait_inj", cutInj, injAll);
        #2 rst = 1'b0;
        #1;
        check("async_inj_drop", cutInj, '0);
        check("rst_mid_valid", resValid, 1'b0);
        check("rst_mid_run_cnt", runCnt, 0);
        check("rst_mid_fail_cnt", failCnt, 0);
        void'(sb.pop_back());
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_idle", vecReady, 1'b1);
        check("rst_mid_cut_start", cutStart, 1'b0);
        check("rst_mid_res_valid", resValid, 1'b0);
        tick();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
